// File: rtl/lut_vec.sv
// Vectorised LUT activation unit: streams a snapshotted N-element operand through P
// LUT-RAM read ports and collects the returned data into a registered result vector.
module lut_vec #(
    parameter int N      = 176,
    parameter int P      = 4,
    parameter int W      = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    output logic [P*W-1:0] x_o,
    output logic           x_vld_o,
    input  logic [P*W-1:0] y_i,
    input  logic [N*W-1:0] X_in,
    input  logic           start,
    input  logic           bypass,
    output logic [N*W-1:0] Y_out,
    output logic           busy,
    output logic           done
);

    localparam int B  = N / P;
    localparam int CW = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    if (N % P != 0) begin : g_bad_np
        $error("lut_vec: N must be a multiple of P");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("lut_vec: RD_LAT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N*W-1:0]  snap;
    logic [CW-1:0]   ctr;
    logic            pipe_vld [RD_LAT];
    logic [CW-1:0]   pipe_idx [RD_LAT];
    logic            last_wr;

    // The beat leaving the pipe this cycle is the final one of the job.
    assign last_wr = pipe_vld[RD_LAT-1] && (pipe_idx[RD_LAT-1] == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, otherwise unlisted paths infer latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = bypass ? DONE : ISSUE;
            ISSUE:   if (ctr == LAST) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_o     = '0;
        x_vld_o = 1'b0;
        if (state == ISSUE) begin
            x_vld_o = 1'b1;
            x_o     = snap[int'(ctr) * (P*W) +: P*W];
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: Y_out is a plain register bank, so it is reset; an aborted job must leave it cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap  <= '0;
            ctr   <= '0;
            Y_out <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            if (state == IDLE && start) begin
                snap <= X_in;
                ctr  <= '0;
                if (bypass) Y_out <= X_in;
            end
            if (state == ISSUE) ctr <= (ctr == LAST) ? '0 : ctr + 1'b1;

            pipe_vld[0] <= (state == ISSUE);
            pipe_idx[0] <= ctr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            // Returned lanes land on the elements of the beat that requested them.
            if (pipe_vld[RD_LAT-1])
                Y_out[int'(pipe_idx[RD_LAT-1]) * (P*W) +: P*W] <= y_i;
        end
    end

endmodule

// File: tb/tb_lut_vec.sv
// Scoreboard bench for lut_vec: one main instance (P=4, RD_LAT=1) for directed jobs and
// a set of parameter variants, each with a LUT-RAM model and an expected-result queue.
module tb_lut_vec;

    localparam int N = 176;
    localparam int W = 8;

    typedef struct {
        logic [N*W-1:0] y;
        int             start_cyc;
        int             lat;
        int             beats;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_m = 1'b1;
    logic rst_g = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lut_f(input int mode, input logic [7:0] v);
        case (mode)
            1:       return ~v;
            2:       return v ^ 8'h3C;
            3:       return v + 8'h11;
            default: return v;
        endcase
    endfunction

    function automatic logic [N*W-1:0] map_vec(input int mode, input logic [N*W-1:0] x);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = lut_f(mode, x[i*W +: W]);
        return r;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < N; i++) begin
                if (act[i*W +: W] !== exp[i*W +: W]) begin
                    $display("FAIL %s: element %0d got %0h expected %0h", name, i,
                             act[i*W +: W], exp[i*W +: W]);
                    break;
                end
            end
        end
    endtask

    // ---------------- main instance ----------------
    logic [4*W-1:0] x_o_m, y_i_m, m_pipe;
    logic           x_vld_o_m, start_m, bypass_m, busy_m, done_m;
    logic [N*W-1:0] X_in_m, Y_out_m;
    int             m_mode = 0;
    exp_t           m_q[$];

    lut_vec #(.N(N), .P(4), .W(W), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst_m), .x_o(x_o_m), .x_vld_o(x_vld_o_m), .y_i(y_i_m),
        .X_in(X_in_m), .start(start_m), .bypass(bypass_m), .Y_out(Y_out_m),
        .busy(busy_m), .done(done_m)
    );

    always @(posedge clk) m_pipe <= x_o_m;

    always_comb begin
        y_i_m = '0;
        for (int l = 0; l < 4; l++) y_i_m[l*W +: W] = lut_f(m_mode, m_pipe[l*W +: W]);
    end

    initial begin
        int   beats;
        exp_t e;
        beats = 0;
        forever begin
            @(negedge clk);
            if (rst_m) beats = 0;
            else begin
                if (x_vld_o_m) beats++;
                if (done_m) begin
                    if (m_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL main_unexpected_done: done at cycle %0d, expected none", cyc);
                    end else begin
                        e = m_q.pop_front();
                        check_val("main_done_cycle", 64'(cyc - e.start_cyc), 64'(e.lat));
                        check_val("main_beats", 64'(beats), 64'(e.beats));
                        check_vec("main_y", Y_out_m, e.y);
                    end
                    beats = 0;
                end
            end
        end
    end

    task automatic start_job_m(input logic [N*W-1:0] x, input logic byp, input logic push,
                               input logic [N*W-1:0] y, input int lat, input int beats);
        exp_t e;
        @(negedge clk);
        X_in_m   = x;
        bypass_m = byp;
        start_m  = 1'b1;
        if (push) begin
            e.y = y; e.start_cyc = cyc; e.lat = lat; e.beats = beats;
            m_q.push_back(e);
        end
        @(negedge clk);
        start_m  = 1'b0;
        bypass_m = 1'b0;
    endtask

    task automatic wait_idle_m();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!busy_m) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL main_timeout: busy still 1, expected 0");
        end
    endtask

    // ---------------- parameter variants ----------------
    function automatic int cfg_p(input int k);
        case (k) 0: return 4; 1: return 1; 2: return 2; 3: return 8; default: return 16; endcase
    endfunction

    function automatic int cfg_l(input int k);
        case (k) 0: return 3; 1: return 1; 2: return 2; 3: return 1; default: return 3; endcase
    endfunction

    for (genvar gk = 0; gk < 5; gk++) begin : g_cfg
        localparam int GP = cfg_p(gk);
        localparam int GL = cfg_l(gk);
        localparam int GM = (gk == 0) ? 1 : 2;

        logic [GP*W-1:0] x_o, y_i;
        logic [GP*W-1:0] pipe [GL];
        logic            x_vld, start, byp, busy, done;
        logic            fin = 1'b0;
        logic [N*W-1:0]  X_in, Y_out;
        exp_t            q[$];

        lut_vec #(.N(N), .P(GP), .W(W), .RD_LAT(GL)) u_dut (
            .clk(clk), .rst(rst_g), .x_o(x_o), .x_vld_o(x_vld), .y_i(y_i),
            .X_in(X_in), .start(start), .bypass(byp), .Y_out(Y_out),
            .busy(busy), .done(done)
        );

        always @(posedge clk) begin
            pipe[0] <= x_o;
            for (int i = 1; i < GL; i++) pipe[i] <= pipe[i-1];
        end

        always_comb begin
            y_i = '0;
            for (int l = 0; l < GP; l++) y_i[l*W +: W] = lut_f(GM, pipe[GL-1][l*W +: W]);
        end

        initial begin
            int   beats;
            exp_t e;
            beats = 0;
            forever begin
                @(negedge clk);
                if (!rst_g) begin
                    if (x_vld) beats++;
                    if (done) begin
                        if (q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL g%0d_unexpected_done: done at cycle %0d, expected none", gk, cyc);
                        end else begin
                            e = q.pop_front();
                            check_val($sformatf("g%0d_done_cycle", gk), 64'(cyc - e.start_cyc), 64'(e.lat));
                            check_val($sformatf("g%0d_beats", gk), 64'(beats), 64'(e.beats));
                            check_vec($sformatf("g%0d_y", gk), Y_out, e.y);
                        end
                        beats = 0;
                    end
                end
            end
        end

        initial begin
            logic [N*W-1:0] x;
            exp_t           e;
            logic           ok;
            start = 1'b0; byp = 1'b0; X_in = '0; x = '0;
            while (rst_g) @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < N; i++) x[i*W +: W] = (gk == 0) ? 8'(i + 5) : 8'(i * 3 + gk);
            X_in  = x;
            start = 1'b1;
            e.y = map_vec(GM, x); e.start_cyc = cyc; e.lat = N / GP + GL + 1; e.beats = N / GP;
            q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            X_in  = ~x;
            ok = 1'b0;
            for (int t = 0; t < 400; t++) begin
                if (!busy) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL g%0d_timeout: busy still 1, expected 0", gk);
            end
            @(negedge clk);
            check_val($sformatf("g%0d_pending", gk), 64'(q.size()), 64'd0);
            fin = 1'b1;
        end
    end

    // ---------------- directed sequence on the main instance ----------------
    initial begin
        logic [N*W-1:0] xa, xb, xc;
        logic           all_fin;
        start_m = 1'b0; bypass_m = 1'b0; X_in_m = '0;
        xa = '0; xb = '0; xc = '0;

        repeat (3) @(negedge clk);
        rst_m = 1'b0;
        rst_g = 1'b0;
        @(negedge clk);
        check_vec("reset_y", Y_out_m, '0);
        check_val("reset_busy", 64'(busy_m), 64'd0);
        check_val("reset_done", 64'(done_m), 64'd0);
        check_val("reset_vld", 64'(x_vld_o_m), 64'd0);
        check_val("reset_x_o", 64'(x_o_m), 64'd0);

        // Identity LUT: first and last beats, done in cycle 46.
        m_mode = 0;
        for (int i = 0; i < N; i++) xa[i*W +: W] = 8'(i);
        start_job_m(xa, 1'b0, 1'b1, xa, 46, 44);
        check_val("t1_vld_first", 64'(x_vld_o_m), 64'd1);
        check_val("t1_x_o_first", 64'(x_o_m), 64'h0302_0100);
        repeat (43) @(negedge clk);
        check_val("t1_vld_last", 64'(x_vld_o_m), 64'd1);
        check_val("t1_x_o_last", 64'(x_o_m), 64'hAFAE_ADAC);
        @(negedge clk);
        check_val("t1_vld_drain", 64'(x_vld_o_m), 64'd0);
        check_val("t1_x_o_drain", 64'(x_o_m), 64'd0);
        wait_idle_m();

        // Bypass: Y = X, done in cycle 1, no reads.
        for (int i = 0; i < N; i++) xb[i*W +: W] = 8'hA5 ^ 8'(i);
        start_job_m(xb, 1'b1, 1'b1, xb, 1, 0);
        wait_idle_m();

        // Scrambled operand and stray starts; a start held through DONE is taken the cycle after.
        m_mode = 3;
        for (int i = 0; i < N; i++) xa[i*W +: W] = 8'(i * 7);
        for (int i = 0; i < N; i++) xb[i*W +: W] = 8'(255 - i);
        start_job_m(xa, 1'b0, 1'b1, map_vec(3, xa), 46, 44);
        for (int k = 2; k <= 45; k++) begin
            @(negedge clk);
            for (int j = 0; j < N * W / 32; j++) X_in_m[j*32 +: 32] = $urandom;
            start_m  = (k % 5 == 0);
            bypass_m = (k % 10 == 0);
        end
        @(negedge clk);
        X_in_m = xb; start_m = 1'b1; bypass_m = 1'b1;
        @(negedge clk);
        begin
            exp_t e;
            e.y = xb; e.start_cyc = cyc; e.lat = 1; e.beats = 0;
            m_q.push_back(e);
        end
        @(negedge clk);
        start_m = 1'b0; bypass_m = 1'b0;
        wait_idle_m();

        // Reset in cycle 20 of a job aborts it and clears Y_out.
        m_mode = 2;
        for (int i = 0; i < N; i++) xc[i*W +: W] = 8'(i) ^ 8'h5A;
        start_job_m(xc, 1'b0, 1'b0, '0, 0, 0);
        repeat (19) @(negedge clk);
        rst_m = 1'b1;
        @(negedge clk);
        check_vec("t5_abort_y", Y_out_m, '0);
        check_val("t5_abort_busy", 64'(busy_m), 64'd0);
        check_val("t5_abort_done", 64'(done_m), 64'd0);
        rst_m = 1'b0;
        for (int i = 0; i < N; i++) xc[i*W +: W] = 8'(i * 11 + 1);
        start_job_m(xc, 1'b0, 1'b1, map_vec(2, xc), 46, 44);
        wait_idle_m();

        all_fin = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            all_fin = g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin & g_cfg[3].fin & g_cfg[4].fin;
            if (all_fin) break;
            @(negedge clk);
        end
        if (!all_fin) begin
            checks++;
            failures++;
            $display("FAIL variants_timeout: not all variant jobs finished, expected all");
        end
        @(negedge clk);
        check_val("main_pending", 64'(m_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
